keccak_sponge_control: RTL and testbench

Sequencer for one Keccak-200 sponge hash (absorb, pad, permute, squeeze) around the round-based permutation core and its lane-serial state datapath.
- Accepts W-bit message words over a valid/ready handshake and generates pad10*1 padding words.
- Starts the permutation core by releasing its reset, waits for its Ready, and streams digest words out over a valid/ready handshake.
- Selects datapath lanes only; state storage and the permutation live outside this block.

---
 rtl/keccak_sponge_control.sv | 163 ++++++++++++++++
 tb/tb_keccak_sponge_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_sponge_control.sv
// Sequencer for one Keccak-200 sponge hash: absorbs message words, generates pad10*1
// padding, runs the external permutation core and streams digest lane indices out.
module keccak_sponge_control #(
    parameter int W          = 8,
    parameter int RATE_WORDS = 9,
    parameter int OUT_WORDS  = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         InValidxSI,
    input  logic         InLastxSI,
    input  logic [W-1:0] DataInxDI,
    output logic         InReadyxSO,
    output logic         AbsorbEnxSO,
    output logic [W-1:0] AbsorbWordxDO,
    output logic [4:0]   AbsorbIdxxDO,
    output logic         PermResetxSO,
    input  logic         PermReadyxSI,
    output logic         OutValidxSO,
    output logic [4:0]   OutIdxxDO,
    input  logic         OutReadyxSI,
    output logic         DonexSO,
    output logic [2:0]   StatexDO
);

    // Handshakes: a message word transfers on a rising edge where InValidxSI and
    // InReadyxSO are both 1; a digest word transfers where OutValidxSO and OutReadyxSI
    // are both 1. Valid never depends on ready on either side.

    typedef enum logic [2:0] {
        ST_ABSORB  = 3'd0,
        ST_PAD     = 3'd1,
        ST_PERM    = 3'd2,
        ST_SQUEEZE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int OCW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam logic [4:0]     LAST_WORD = 5'(RATE_WORDS - 1);
    localparam logic [OCW-1:0] LAST_OUT  = OCW'(OUT_WORDS - 1);

    state_e         state_q, state_d;
    logic [4:0]     word_cnt_q, word_cnt_d;
    logic [OCW-1:0] out_cnt_q, out_cnt_d;
    logic           pad_pending_q, pad_pending_d;
    logic           pad_first_q, pad_first_d;
    logic           final_q, final_d;

    logic           word_last;
    logic [W-1:0]   pad_word;

    assign word_last = (word_cnt_q == LAST_WORD);

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        out_cnt_d     = out_cnt_q;
        pad_pending_d = pad_pending_q;
        pad_first_d   = pad_first_q;
        final_d       = final_q;
        case (state_q)
            ST_ABSORB: begin
                if (InValidxSI) begin
                    if (word_last) begin
                        // A last word filling the block leaves a whole padding block to do.
                        state_d       = ST_PERM;
                        word_cnt_d    = '0;
                        pad_pending_d = InLastxSI;
                    end else begin
                        word_cnt_d = word_cnt_q + 5'd1;
                        if (InLastxSI) begin
                            state_d     = ST_PAD;
                            pad_first_d = 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                pad_first_d = 1'b0;
                if (word_last) begin
                    state_d       = ST_PERM;
                    word_cnt_d    = '0;
                    final_d       = 1'b1;
                    pad_pending_d = 1'b0;
                end else begin
                    word_cnt_d = word_cnt_q + 5'd1;
                end
            end
            ST_PERM: begin
                if (PermReadyxSI) begin
                    if (final_q) begin
                        state_d = ST_SQUEEZE;
                    end else if (pad_pending_q) begin
                        state_d     = ST_PAD;
                        word_cnt_d  = '0;
                        pad_first_d = 1'b1;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end
            ST_SQUEEZE: begin
                if (OutReadyxSI) begin
                    if (out_cnt_q == LAST_OUT) begin
                        state_d = ST_DONE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (word_last) begin
                            state_d    = ST_PERM;
                            word_cnt_d = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + 5'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ABSORB;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_ABSORB;
            word_cnt_q    <= '0;
            out_cnt_q     <= '0;
            pad_pending_q <= 1'b0;
            pad_first_q   <= 1'b0;
            final_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            out_cnt_q     <= out_cnt_d;
            pad_pending_q <= pad_pending_d;
            pad_first_q   <= pad_first_d;
            final_q       <= final_d;
        end
    end

    // pad10*1: leading 1 in bit 0 of the first pad word, trailing 1 in the MSB of the last lane.
    always_comb begin
        pad_word        = '0;
        pad_word[0]     = pad_first_q;
        pad_word[W-1]   = pad_word[W-1] | word_last;
    end

    always_comb begin
        InReadyxSO    = (state_q == ST_ABSORB);
        AbsorbEnxSO   = ((state_q == ST_ABSORB) && InValidxSI) || (state_q == ST_PAD);
        AbsorbWordxDO = (state_q == ST_PAD) ? pad_word : DataInxDI;
        AbsorbIdxxDO  = ((state_q == ST_ABSORB) || (state_q == ST_PAD)) ? word_cnt_q : 5'd0;
        PermResetxSO  = (state_q != ST_PERM);
        OutValidxSO   = (state_q == ST_SQUEEZE);
        OutIdxxDO     = (state_q == ST_SQUEEZE) ? word_cnt_q : 5'd0;
        DonexSO       = (state_q == ST_DONE);
        StatexDO      = state_q;
    end

endmodule

// File: tb/tb_keccak_sponge_control.sv
// Randomized bench for keccak_sponge_control: a padded-message / digest-index reference
// model plus a latency-driven permutation core model score every absorb, squeeze and perm.
module tb_keccak_sponge_control;

    localparam int W  = 8;
    localparam int R  = 9;
    localparam int OW = 16;

    logic         Clock;
    logic         Reset;
    logic         InValidxSI;
    logic         InLastxSI;
    logic [W-1:0] DataInxDI;
    logic         InReadyxSO;
    logic         AbsorbEnxSO;
    logic [W-1:0] AbsorbWordxDO;
    logic [4:0]   AbsorbIdxxDO;
    logic         PermResetxSO;
    logic         PermReadyxSI;
    logic         OutValidxSO;
    logic [4:0]   OutIdxxDO;
    logic         OutReadyxSI;
    logic         DonexSO;
    logic [2:0]   StatexDO;

    keccak_sponge_control #(.W(W), .RATE_WORDS(R), .OUT_WORDS(OW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .InValidxSI    (InValidxSI),
        .InLastxSI     (InLastxSI),
        .DataInxDI     (DataInxDI),
        .InReadyxSO    (InReadyxSO),
        .AbsorbEnxSO   (AbsorbEnxSO),
        .AbsorbWordxDO (AbsorbWordxDO),
        .AbsorbIdxxDO  (AbsorbIdxxDO),
        .PermResetxSO  (PermResetxSO),
        .PermReadyxSI  (PermReadyxSI),
        .OutValidxSO   (OutValidxSO),
        .OutIdxxDO     (OutIdxxDO),
        .OutReadyxSI   (OutReadyxSI),
        .DonexSO       (DonexSO),
        .StatexDO      (StatexDO)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [12:0]  exp_abs_q[$];
    logic [4:0]   exp_out_q[$];
    logic [W-1:0] msg [0:63];
    int ptr, lat, low_cnt, perms, exp_perms;
    bit acc, out_tog;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: message words, then pad10*1 up to the next whole block; digest lanes
    // are read block by block with a permutation between digest blocks.
    task automatic build_model(input int len);
        int n;
        logic [W-1:0] w;
        exp_abs_q.delete();
        exp_out_q.delete();
        n = (len / R + 1) * R;
        for (int i = 0; i < n; i++) begin
            w = (i < len) ? msg[i] : '0;
            if (i == len) w = w | 8'h01;
            if (i == n - 1) w = w | 8'h80;
            exp_abs_q.push_back({5'(i % R), w});
        end
        for (int j = 0; j < OW; j++) exp_out_q.push_back(5'(j % R));
        exp_perms = n / R + (OW + R - 1) / R - 1;
    endtask

    // Called at a falling edge; leaves the DUT in its post-reset state.
    task automatic do_reset();
        Reset        = 1'b1;
        InValidxSI   = 1'b0;
        InLastxSI    = 1'b0;
        OutReadyxSI  = 1'b0;
        PermReadyxSI = 1'b0;
        DataInxDI    = W'($urandom);
        @(negedge Clock);
        DataInxDI = W'($urandom);
        InLastxSI = 1'b1;
        #1;
        check("rst_inready",   InReadyxSO, 1);
        check("rst_absorb_en", AbsorbEnxSO, 0);
        check("rst_perm_rst",  PermResetxSO, 1);
        check("rst_outvalid",  OutValidxSO, 0);
        check("rst_done",      DonexSO, 0);
        check("rst_abs_idx",   AbsorbIdxxDO, 0);
        check("rst_out_idx",   OutIdxxDO, 0);
        check("rst_abs_word",  AbsorbWordxDO, DataInxDI);
        Reset     = 1'b0;
        InLastxSI = 1'b0;
        low_cnt   = 0;
        acc       = 1'b0;
    endtask

    // abort_at: 0 = run to completion, 1 = reset mid-permutation, 2 = reset mid-squeeze
    task automatic run_hash(input int len, input int latency, input bit cont,
                            input bit tog_mode, input int abort_at);
        bit done;
        logic [12:0] e;
        lat = latency;
        for (int i = 0; i < len; i++) msg[i] = W'($urandom);
        build_model(len);
        ptr = 0; acc = 1'b0; perms = 0; low_cnt = 0; done = 1'b0; out_tog = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge Clock);
            // permutation core: Ready after 'lat' cycles out of reset; stray pulses otherwise
            if (!PermResetxSO) begin
                low_cnt++;
                PermReadyxSI = (low_cnt == lat);
            end else begin
                if (low_cnt != 0) begin
                    check("perm_len", low_cnt, lat);
                    perms++;
                    low_cnt = 0;
                end
                PermReadyxSI = ($urandom_range(0, 7) == 0);
            end
            if ((abort_at == 1 && low_cnt == 3) ||
                (abort_at == 2 && OutValidxSO && exp_out_q.size() <= OW - 3)) begin
                do_reset();
                return;
            end
            // message driver: valid is held until the word is taken
            if (acc) begin
                InValidxSI = 1'b0;
                acc = 1'b0;
            end
            if (!InValidxSI) begin
                if (ptr < len && (cont || $urandom_range(0, 3) != 0)) begin
                    InValidxSI = 1'b1;
                    DataInxDI  = msg[ptr];
                    InLastxSI  = (ptr == len - 1);
                end else begin
                    DataInxDI = W'($urandom);
                    InLastxSI = 1'($urandom);
                end
            end
            if (tog_mode) begin
                out_tog = ~out_tog;
                OutReadyxSI = out_tog;
            end else begin
                OutReadyxSI = 1'($urandom_range(0, 1));
            end
            #1;
            if (InValidxSI && InReadyxSO) begin
                acc = 1'b1;
                ptr++;
            end
            if (AbsorbEnxSO) begin
                if (exp_abs_q.size() == 0) begin
                    check("absorb_extra", 1, 0);
                end else begin
                    e = exp_abs_q.pop_front();
                    check("absorb_idx", AbsorbIdxxDO, e[12:8]);
                    check("absorb_word", AbsorbWordxDO, e[7:0]);
                end
            end else if (InValidxSI && InReadyxSO) begin
                check("absorb_en", 0, 1);
            end
            if (OutValidxSO) begin
                if (exp_out_q.size() == 0) begin
                    check("out_extra", 1, 0);
                end else begin
                    check("out_idx", OutIdxxDO, exp_out_q[0]);
                    if (OutReadyxSI) void'(exp_out_q.pop_front());
                end
            end
            if (DonexSO) begin
                done = 1'b1;
                check("done_abs_left", exp_abs_q.size(), 0);
                check("done_out_left", exp_out_q.size(), 0);
                check("perm_count", perms, exp_perms);
                check("done_inready", InReadyxSO, 0);
                check("done_outvalid", OutValidxSO, 0);
            end
        end
        if (!done) check("timeout", 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            PermReadyxSI = 1'($urandom);
            OutReadyxSI  = 1'($urandom);
            InValidxSI   = 1'($urandom);
            #1;
            check("done_held", DonexSO, 1);
            check("done_perm_rst", PermResetxSO, 1);
            check("done_absorb_en", AbsorbEnxSO, 0);
        end
        @(negedge Clock);
        do_reset();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        Reset = 1'b1; InValidxSI = 1'b0; InLastxSI = 1'b0; DataInxDI = '0;
        PermReadyxSI = 1'b0; OutReadyxSI = 1'b0;
        repeat (2) @(negedge Clock);
        do_reset();
        run_hash(9, 20, 1'b1, 1'b1, 0);
        run_hash(3, 20, 1'b1, 1'b1, 0);
        run_hash(8, 20, 1'b1, 1'b0, 0);
        run_hash(9, 20, 1'b1, 1'b0, 1);
        run_hash(9, 20, 1'b1, 1'b1, 0);
        run_hash(10, 7, 1'b0, 1'b0, 2);
        run_hash(9, 5, 1'b0, 1'b1, 0);
        run_hash(1, 1, 1'b0, 1'b0, 0);
        run_hash(18, 2, 1'b0, 1'b0, 0);
        for (int t = 0; t < 8; t++) begin
            run_hash(int'($urandom_range(1, 30)), int'($urandom_range(1, 25)),
                     1'($urandom), 1'($urandom), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
